// File: rtl/mantissa_seq_multiplier.sv
// rtl/mantissa_seq_multiplier.sv - radix-2 shift-add mantissa multiplier with normalization
// Optional round-to-nearest-even on the result when MUL_ROUND_EN is defined.
module mantissa_seq_multiplier #(
  parameter int MAN_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MAN_WIDTH-1:0] man_x,
  input  logic [MAN_WIDTH-1:0] man_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MAN_WIDTH-1:0] result,
  output logic                 exp_inc,
  output logic [MAN_WIDTH-1:0] redundant_mul,
  output logic                 busy
);
  localparam int W     = MAN_WIDTH;
  localparam int CNT_W = $clog2(MAN_WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_NORM, S_DONE} state_t;

  state_t           r_state;
  logic [W-1:0]     r_x;
  logic [2*W-1:0]   r_p;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic [W-1:0]     r_result;
  logic             r_exp_inc;
  logic [W-1:0]     r_red;

  logic [W:0]       w_sum;
  logic [W-1:0]     w_norm_res;
  logic [W-1:0]     w_norm_red;
  logic             w_norm_inc;
`ifdef MUL_ROUND_EN
  logic             w_round_up;
`endif

  // Adder is one bit wider than the partial product so the carry lands in the shift.
  assign w_sum = {1'b0, r_p[2*W-1:W]} + (r_p[0] ? {1'b0, r_x} : {(W+1){1'b0}});

  always_comb begin
    w_norm_inc = r_p[2*W-1];
    if (r_p[2*W-1]) begin
      w_norm_res = r_p[2*W-1:W];
      w_norm_red = r_p[W-1:0];
    end else begin
      w_norm_res = r_p[2*W-2:W-1];
      w_norm_red = {r_p[W-2:0], 1'b0};
    end
`ifdef MUL_ROUND_EN
    w_round_up = w_norm_red[W-1] & ((|w_norm_red[W-2:0]) | w_norm_res[0]);
    if (w_round_up) begin
      if (&w_norm_res) begin
        w_norm_res = {1'b1, {(W-1){1'b0}}};
        w_norm_inc = 1'b1;
      end else begin
        w_norm_res = w_norm_res + {{(W-1){1'b0}}, 1'b1};
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_p         <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= '0;
      r_exp_inc   <= 1'b0;
      r_red       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_x        <= man_x;
            r_p        <= {{W{1'b0}}, man_y};
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_CALC;
          end
        end
        S_CALC: begin
          r_p   <= {w_sum, r_p[W-1:1]};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(W - 1)) begin
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          r_result  <= w_norm_res;
          r_red     <= w_norm_red;
          r_exp_inc <= w_norm_inc;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          // out_valid rises one cycle into DONE; the handshake returns to IDLE.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign busy          = r_busy;
  assign result        = r_result;
  assign exp_inc       = r_exp_inc;
  assign redundant_mul = r_red;

endmodule

// File: tb/tb_mantissa_seq_multiplier.sv
// tb/tb_mantissa_seq_multiplier.sv - directed and random checks of the sequential mantissa multiplier
module tb_mantissa_seq_multiplier;
  localparam int W = 24;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] man_x;
  logic [W-1:0] man_y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         exp_inc;
  logic [W-1:0] redundant_mul;
  logic         busy;

  int n_checks = 0;
  int n_pass   = 0;

  mantissa_seq_multiplier #(.MAN_WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .man_x        (man_x),
    .man_y        (man_y),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .exp_inc      (exp_inc),
    .redundant_mul(redundant_mul),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%h expected=%h", tag, got, exp);
  endtask

  // Reference: exact integer product, then normalise and optionally round by value.
  function automatic logic [2*W:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    longint unsigned xx, yy, p, res, red;
    logic inc;
    xx = x;
    yy = y;
    p  = xx * yy;
    if (p >= (64'd1 << (2*W-1))) begin
      inc = 1'b1;
      res = p >> W;
      red = p % (64'd1 << W);
    end else begin
      inc = 1'b0;
      res = p >> (W-1);
      red = (p % (64'd1 << (W-1))) * 2;
    end
`ifdef MUL_ROUND_EN
    if (red >= (64'd1 << (W-1)) && ((red % (64'd1 << (W-1))) != 0 || (res % 2) == 1)) begin
      res = res + 1;
      if (res == (64'd1 << W)) begin
        res = 64'd1 << (W-1);
        inc = 1'b1;
      end
    end
`endif
    return {inc, res[W-1:0], red[W-1:0]};
  endfunction

  task automatic issue(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
    int g = 0;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_ready_before"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    man_x    = x;
    man_y    = y;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_busy_after_accept"}, 64'({busy, in_ready}), 64'b10);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_after_handshake"}, 64'({out_valid, in_ready, busy}), 64'b010);
  endtask

  task automatic run(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [2*W:0] exp);
    int lat;
    issue(tag, x, y);
    wait_out(lat);
    check({tag, "_latency"}, 64'(lat), 64'(LAT));
    check({tag, "_exp_inc"}, 64'(exp_inc), 64'(exp[2*W]));
    check({tag, "_result"}, 64'(result), 64'(exp[2*W-1:W]));
    check({tag, "_redundant"}, 64'(redundant_mul), 64'(exp[W-1:0]));
    drain(tag);
  endtask

  initial begin
    int lat;
    int spurious;
    logic [W-1:0] rx, ry;
    logic [W-1:0] t4_res;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    man_x     = '0;
    man_y     = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", 64'({in_ready, out_valid, busy, exp_inc}), 64'b1000);
    check("reset_result", 64'(result), 64'd0);
    check("reset_redundant", 64'(redundant_mul), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run("one_x_one", 24'h800000, 24'h800000, {1'b0, 24'h800000, 24'h000000});
    run("c0_sq", 24'hC00000, 24'hC00000, {1'b1, 24'h900000, 24'h000000});
    run("ff_sq", 24'hFFFFFF, 24'hFFFFFF, {1'b1, 24'hFFFFFE, 24'h000001});
`ifdef MUL_ROUND_EN
    t4_res = 24'hC00002;
`else
    t4_res = 24'hC00001;
`endif
    run("tie_round", 24'h800001, 24'hC00000, {1'b0, t4_res, 24'h800000});
    run("zero_op", 24'h000000, 24'hABCDEF, {1'b0, 24'h000000, 24'h000000});

    for (int i = 0; i < 20; i++) begin
      rx = {1'b1, 23'($urandom)};
      ry = {1'b1, 23'($urandom)};
      run($sformatf("rand%0d", i), rx, ry, model(rx, ry));
    end

    // Backpressure: result must hold and no second operand may be taken.
    issue("bp", 24'hC00000, 24'hC00000);
    wait_out(lat);
    check("bp_latency", 64'(lat), 64'(LAT));
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      man_x = 24'($urandom);
      man_y = 24'($urandom);
      @(negedge clk);
      check($sformatf("bp_hold%0d", i),
            64'({out_valid, in_ready, exp_inc, result, redundant_mul}),
            64'({1'b1, 1'b0, 1'b1, 24'h900000, 24'h000000}));
    end
    man_x     = 24'h800000;
    man_y     = 24'h800000;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle", 64'({out_valid, in_ready}), 64'b01);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_reaccept", 64'({busy, in_ready}), 64'b10);
    wait_out(lat);
    check("bp2_latency", 64'(lat), 64'(LAT));
    check("bp2_result", 64'({exp_inc, result, redundant_mul}), 64'({1'b0, 24'h800000, 24'h000000}));
    drain("bp2");

    // Reset in the middle of CALC.
    issue("rst", 24'hFFFFFF, 24'hFFFFFF);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", 64'({in_ready, out_valid, busy, exp_inc}), 64'b1000);
    check("midrst_data", 64'({result, redundant_mul}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    check("midrst_no_spurious", 64'(spurious), 64'd0);
    run("after_rst", 24'hC00000, 24'hC00000, {1'b1, 24'h900000, 24'h000000});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
